// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, legal opcode bytes and the
// command-unpacker FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_MUL = 2'd1,
    OP_DIV = 2'd2
  } opcode_t;

  localparam logic [7:0] OPB_ADD = 8'h00;
  localparam logic [7:0] OPB_MUL = 8'h01;
  localparam logic [7:0] OPB_DIV = 8'h02;

  typedef enum logic [1:0] {
    S_OP,
    S_A,
    S_B,
    S_EMIT
  } unpack_state_t;

  function automatic logic is_legal_op(input logic [7:0] b);
    return (b == OPB_ADD) || (b == OPB_MUL) || (b == OPB_DIV);
  endfunction

endpackage

// File: rtl/alu_cmd_unpack_if.sv
// Byte-stream input and assembled-command output of the ALU command unpacker.
interface alu_cmd_unpack_if
  import alu_pkg::*;
#(
  parameter int width_p = 32
);
  logic               valid_i;
  logic [7:0]         data_i;
  logic               ready_o;
  logic               ready_i;
  logic               valid_o;
  opcode_t            opcode_o;
  logic [width_p-1:0] operand_a_o;
  logic [width_p-1:0] operand_b_o;
  logic               error_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, opcode_o, operand_a_o, operand_b_o, error_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, opcode_o, operand_a_o, operand_b_o, error_o
  );
endinterface

// File: rtl/alu_cmd_unpack.sv
// Assembles UART bytes into {opcode, A, B} commands (operands little-endian)
// and hands them to the ALU over a registered valid/ready interface.
module alu_cmd_unpack
  import alu_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  alu_cmd_unpack_if.slave  bus
);

  localparam int NB = width_p / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  unpack_state_t      r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic               r_valid, r_err;
  opcode_t            r_opcode;
  logic [width_p-1:0] r_a, r_b;

  logic w_ready, w_accept, w_last, w_legal;
  logic w_lat_op, w_wr_a, w_wr_b, w_err, w_set_vld, w_clr_vld, w_cnt_clr, w_cnt_inc;

  assign w_ready  = (r_state != S_EMIT) | bus.ready_i;
  assign w_accept = bus.valid_i & w_ready;
  assign w_last   = (r_cnt == LAST);
  assign w_legal  = is_legal_op(bus.data_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_OP;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lat_op    = 1'b0;
    w_wr_a      = 1'b0;
    w_wr_b      = 1'b0;
    w_err       = 1'b0;
    w_set_vld   = 1'b0;
    w_clr_vld   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_OP: begin
        if (w_accept) begin
          if (w_legal) begin
            w_lat_op    = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_A;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_A: begin
        if (w_accept) begin
          w_wr_a = 1'b1;
          if (w_last) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_B;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_B: begin
        if (w_accept) begin
          w_wr_b = 1'b1;
          if (w_last) begin
            w_cnt_clr   = 1'b1;
            w_set_vld   = 1'b1;
            w_state_nxt = S_EMIT;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_EMIT: begin
        // The byte arriving alongside the output handshake is the next opcode.
        if (bus.ready_i) begin
          w_clr_vld   = 1'b1;
          w_state_nxt = S_OP;
          if (w_accept) begin
            if (w_legal) begin
              w_lat_op    = 1'b1;
              w_cnt_clr   = 1'b1;
              w_state_nxt = S_A;
            end else begin
              w_err = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = S_OP;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_opcode <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      r_err <= w_err;
      if (w_set_vld)      r_valid <= 1'b1;
      else if (w_clr_vld) r_valid <= 1'b0;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_lat_op) r_opcode <= opcode_t'(bus.data_i[1:0]);
      // Lanes are overwritten in place; no clear is needed between packets.
      if (w_wr_a) r_a[{r_cnt, 3'b000} +: 8] <= bus.data_i;
      if (w_wr_b) r_b[{r_cnt, 3'b000} +: 8] <= bus.data_i;
    end
  end

  assign bus.ready_o     = w_ready;
  assign bus.valid_o     = r_valid;
  assign bus.opcode_o    = r_opcode;
  assign bus.operand_a_o = r_a;
  assign bus.operand_b_o = r_b;
  assign bus.error_o     = r_err;

endmodule

// File: tb/tb_alu_cmd_unpack.sv
// Directed and randomized bench for alu_cmd_unpack with a packet scoreboard.
module tb_alu_cmd_unpack;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_unpack_if #(.width_p(W)) bus();

  alu_cmd_unpack #(.width_p(W)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   err_cyc = -1;
  int   err_pulses = 0;
  int   emitted = 0;
  int   pushed = 0;
  bit   last_acc = 1'b0;
  bit   prev_valid = 1'b0;
  bit   rnd_ready = 1'b0;
  int   rise_q[$];
  pkt_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor at the falling edge, then return just after the rising edge.
  task automatic tick();
    pkt_t e;
    if (rnd_ready) bus.ready_i = 1'($urandom_range(0, 1));
    @(negedge clk);
    last_acc = bus.valid_i & bus.ready_o;
    if (last_acc) acc_cyc = cyc;
    if (bus.valid_o && !prev_valid) rise_q.push_back(cyc);
    prev_valid = bus.valid_o;
    if (bus.error_o) begin
      err_pulses++;
      err_cyc = cyc;
    end
    if (bus.valid_o && bus.ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("opcode", 64'(bus.opcode_o), 64'(e.op));
        chk("operand_a", 64'(bus.operand_a_o), 64'(e.a));
        chk("operand_b", 64'(bus.operand_b_o), 64'(e.b));
        emitted++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    bus.valid_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int n;
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    if (gap > 0) idle(gap);
    bus.valid_i = 1'b1;
    bus.data_i  = b;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_packet(input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int maxgap);
    pkt_t p;
    p.op = op; p.a = a; p.b = b;
    sb.push_back(p);
    pushed++;
    send_byte({6'd0, op}, maxgap);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], maxgap);
    for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8], maxgap);
  endtask

  initial begin
    int e0, a7f;
    logic [31:0] ra, rb;
    logic [1:0]  rop;

    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    bus.ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.valid_o), 64'(0));
    chk("rst_opcode", 64'(bus.opcode_o), 64'(0));
    chk("rst_a", 64'(bus.operand_a_o), 64'(0));
    chk("rst_b", 64'(bus.operand_b_o), 64'(0));
    chk("rst_error", 64'(bus.error_o), 64'(0));
    chk("rst_ready", 64'(bus.ready_o), 64'(1));
    rst = 1'b0;
    idle(2);

    // Add packet with latency check
    rise_q.delete();
    send_packet(2'd0, 32'h01020304, 32'h05060708, 0);
    idle(1);
    chk("add_latency", 64'(rise_q.size() > 0 ? rise_q[0] : -1), 64'(acc_cyc + 1));
    idle(2);

    // Backpressure on a div packet
    bus.ready_i = 1'b0;
    send_packet(2'd2, 32'hFFFFFFFF, 32'h00000010, 0);
    bus.valid_i = 1'b1;
    bus.data_i  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 64'(bus.valid_o), 64'(1));
      chk("bp_ready", 64'(bus.ready_o), 64'(0));
      chk("bp_not_consumed", 64'(last_acc), 64'(0));
      chk("bp_opcode", 64'(bus.opcode_o), 64'(2));
      chk("bp_a", 64'(bus.operand_a_o), 64'(32'hFFFFFFFF));
      chk("bp_b", 64'(bus.operand_b_o), 64'(32'h00000010));
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    tick();
    chk("bp_release", 64'(bus.valid_o), 64'(0));
    idle(2);

    // Back-to-back mul packets
    rise_q.delete();
    send_packet(2'd1, 32'hDEADBEEF, 32'h12345678, 0);
    send_packet(2'd1, 32'hCAFEF00D, 32'h0BADC0DE, 0);
    idle(3);
    chk("b2b_pulses", 64'(rise_q.size()), 64'(2));
    chk("b2b_spacing", 64'(rise_q.size() == 2 ? rise_q[1] - rise_q[0] : -1), 64'(9));

    // Illegal opcode then a legal add
    e0 = err_pulses;
    send_byte(8'h7F, 0);
    a7f = acc_cyc;
    idle(3);
    chk("illegal_pulses", 64'(err_pulses - e0), 64'(1));
    chk("illegal_timing", 64'(err_cyc), 64'(a7f + 1));
    chk("illegal_no_valid", 64'(bus.valid_o), 64'(0));
    send_packet(2'd0, 32'h11223344, 32'h55667788, 0);
    idle(3);

    // Asynchronous reset mid-packet
    send_byte(8'h01, 0);
    for (int i = 0; i < 3; i++) send_byte(8'h90 + 8'(i), 0);
    bus.valid_i = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.valid_o), 64'(0));
    chk("mid_rst_opcode", 64'(bus.opcode_o), 64'(0));
    chk("mid_rst_a", 64'(bus.operand_a_o), 64'(0));
    chk("mid_rst_b", 64'(bus.operand_b_o), 64'(0));
    chk("mid_rst_error", 64'(bus.error_o), 64'(0));
    chk("mid_rst_ready", 64'(bus.ready_o), 64'(1));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    send_packet(2'd2, 32'hA5A5A5A5, 32'h0000_0003, 0);
    idle(3);

    // Randomized gaps and downstream stalls
    rnd_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      rop = 2'($urandom_range(0, 2));
      ra  = $urandom;
      rb  = $urandom;
      send_packet(rop, ra, rb, 2);
    end
    bus.valid_i = 1'b0;
    rnd_ready   = 1'b0;
    bus.ready_i = 1'b1;
    idle(5);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    chk("emit_count", 64'(emitted), 64'(pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
